jtag_tap_controller: RTL
========================

// Module: jtag_tap_controller
// PURPOSE
//  Parametrised IEEE 1149.1 TAP: 16-state controller, IR_WIDTH-bit instruction register,
//  BYPASS, optional IDCODE and one DR_WIDTH-bit user data register.
//  Target side of the Jtag pin bus (Tdi/Tms in, Tdo out).
//  Serves as the DUT/reference responder for the Jtag AVIP.
// PARAMETERS
//  IR_WIDTH   4             instruction register width, >=2
//  DR_WIDTH   32            user data register width, >=1
//  IDCODE     32'h1234_5001 IDCODE value; bit0 must be 1
//  IDCODE_OP  'h1           IDCODE opcode (IR_WIDTH bits)
//  USER_OP    'h2           user DR opcode; all-ones opcode is always BYPASS
// PORTS
//  clk         in   1         TCK; all state changes on rising edge
//  reset       in   1         asynchronous, active-high; forces Test-Logic-Reset
//  Tdi         in   1         serial data in
//  Tms         in   1         mode select
//  Tdo         out  1         serial data out
//  TdoEn       out  1         high while in Shift-DR or Shift-IR
//  TapState    out  4         current state encoding, TLR=0 .. UPDATE_IR=15
//  IrValue     out  IR_WIDTH  active instruction
//  UserDrIn    in   DR_WIDTH  parallel value captured in Capture-DR when IR=USER_OP
//  UserDrOut   out  DR_WIDTH  value latched in Update-DR when IR=USER_OP
//  UserUpdate  out  1         one-cycle pulse on the UserDrOut load
// BEHAVIOUR
//  Reset values: TapState=TLR, IrValue=IDCODE_OP, UserDrOut=0, UserUpdate=0, TdoEn=0, Tdo=0.
//  FSM follows the standard 1149.1 Tms graph:
//   TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR, and the same set for IR.
//  Five consecutive Tms=1 edges from any state reach TLR.
//  Entering TLR (by reset or by the Tms path) reloads IrValue to its reset value.
//  Capture-IR: IR shift register <= {0..0,2'b01}.
//  Update-IR: IrValue <= IR shift register.
//  Capture-DR loads the selected DR:
//   - IDCODE_OP: IDCODE
//   - USER_OP: UserDrIn
//   - any other opcode: 1-bit bypass, loaded with 0
//  Shift state, each rising edge: selected register shifts right; Tdi enters the MSB.
//  Tdo = LSB of the selected shift register; combinational from current state.
//  Tdo is forced to 0 when TdoEn=0.
//  Timing: first Tdo bit is valid during the first Shift cycle.
//  The edge that leaves Shift via Exit1 still shifts; a length-N register needs N Shift-state edges.
//  Update-DR with IR=USER_OP: UserDrOut <= shift register.
//   UserUpdate is high for exactly the cycle after the UPD_DR edge.
//  Update-DR with other opcodes: no parallel output changes.
//  Pause states hold all shift registers unchanged.
//  Reset mid-shift: shift contents are discarded; the next capture reloads them.
//  UserDrOut is cleared only by reset, not by the TLR Tms path.
//  Unknown opcodes select BYPASS.
// CONFIGURATION
//  JTAG_IDCODE_EN defined:
//   - IDCODE register present
//   - reset and TLR load IrValue=IDCODE_OP
//  JTAG_IDCODE_EN undefined:
//   - no IDCODE register
//   - IDCODE_OP decodes as BYPASS
//   - reset and TLR load IrValue to all-ones (BYPASS)
// TESTING
//  1. reset=1 then release, Tms=1 held -> TapState=0, IrValue=4'h1 (4'hF without macro), TdoEn=0.
//  2. Tms 0,1,0,0 to SH_DR, then 32 shifts with Tdi=0 -> Tdo LSB-first 0x1234_5001.
//  3. Load IR=4'hF, shift DR pattern 1,0,1,1 -> Tdo 0,1,0,1 (one-bit delay); Capture-IR yields Tdo 1,0,0,0.
//  4. IR=USER_OP, UserDrIn=0xA5A5_0F0F, shift in 0xDEAD_BEEF -> Tdo returns 0xA5A5_0F0F;
//     after Update-DR, UserDrOut=0xDEAD_BEEF and UserUpdate is a 1-cycle pulse.
//  5. In SH_DR or PAU_IR, drive Tms=1 for 5 edges -> TapState=TLR, IrValue=IDCODE_OP.
//  6. Assert reset asynchronously mid Shift-DR -> TapState=TLR, UserDrOut=0 immediately;
//     the next read returns a freshly captured value.

Source files
------------

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP: 16-state controller, instruction register, BYPASS, user DR and optional IDCODE.
// Define JTAG_IDCODE_EN to include the IDCODE register and make IDCODE_OP the reset instruction.
module jtag_tap_controller #(
    parameter int unsigned         IR_WIDTH  = 4,
    parameter int unsigned         DR_WIDTH  = 32,
    parameter logic [31:0]         IDCODE    = 32'h1234_5001,
    parameter logic [IR_WIDTH-1:0] IDCODE_OP = IR_WIDTH'(1),
    parameter logic [IR_WIDTH-1:0] USER_OP   = IR_WIDTH'(2)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Tdi,
    input  logic                Tms,
    output logic                Tdo,
    output logic                TdoEn,
    output logic [3:0]          TapState,
    output logic [IR_WIDTH-1:0] IrValue,
    input  logic [DR_WIDTH-1:0] UserDrIn,
    output logic [DR_WIDTH-1:0] UserDrOut,
    output logic                UserUpdate
);
    typedef enum logic [3:0] {
        TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
        SH_DR  = 4'd4,  EX1_DR = 4'd5,  PAU_DR = 4'd6,  EX2_DR = 4'd7,
        UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
        EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] BYPASS_OP = {IR_WIDTH{1'b1}};
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IR_RESET = IDCODE_OP;
`else
    localparam logic [IR_WIDTH-1:0] IR_RESET = BYPASS_OP;
`endif

    tap_state_e          state_q, state_d;
    logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic                byp_q, byp_d;
    logic [DR_WIDTH-1:0] user_sr_q, user_sr_d;
    logic [DR_WIDTH-1:0] user_out_q, user_out_d;
    logic                user_upd_q, user_upd_d;
    logic                sel_user_s, sel_id_s, id_lsb_s, tdo_s;
    logic [IR_WIDTH:0]   ir_shift_s;
    logic [DR_WIDTH:0]   user_shift_s;

    assign sel_user_s   = (ir_q == USER_OP) && (USER_OP != BYPASS_OP);
    assign ir_shift_s   = {Tdi, ir_sr_q};
    assign user_shift_s = {Tdi, user_sr_q};

`ifdef JTAG_IDCODE_EN
    logic [31:0] id_sr_q, id_sr_d;
    logic [32:0] id_shift_s;

    assign sel_id_s   = (ir_q == IDCODE_OP) && (IDCODE_OP != BYPASS_OP) && !sel_user_s;
    assign id_shift_s = {Tdi, id_sr_q};
    assign id_lsb_s   = id_sr_q[0];

    // IDCODE shift register: capture the constant, shift while selected
    always_comb begin
        id_sr_d = id_sr_q;
        if (sel_id_s && (state_q == CAP_DR)) begin
            id_sr_d = IDCODE;
        end else if (sel_id_s && (state_q == SH_DR)) begin
            id_sr_d = id_shift_s[32:1];
        end else begin
            id_sr_d = id_sr_q;
        end
    end

    // IDCODE shift register storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) id_sr_q <= 32'h0000_0000;
        else       id_sr_q <= id_sr_d;
    end
`else
    // Without the IDCODE register its opcode falls through to BYPASS.
    assign sel_id_s = (ir_q == IDCODE_OP) & 1'b0;
    assign id_lsb_s = IDCODE[0] & 1'b0;
`endif

    // Tms-driven state graph
    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:     state_d = Tms ? TLR    : RTI;
            RTI:     state_d = Tms ? SEL_DR : RTI;
            SEL_DR:  state_d = Tms ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = Tms ? EX1_DR : SH_DR;
            SH_DR:   state_d = Tms ? EX1_DR : SH_DR;
            EX1_DR:  state_d = Tms ? UPD_DR : PAU_DR;
            PAU_DR:  state_d = Tms ? EX2_DR : PAU_DR;
            EX2_DR:  state_d = Tms ? UPD_DR : SH_DR;
            UPD_DR:  state_d = Tms ? SEL_DR : RTI;
            SEL_IR:  state_d = Tms ? TLR    : CAP_IR;
            CAP_IR:  state_d = Tms ? EX1_IR : SH_IR;
            SH_IR:   state_d = Tms ? EX1_IR : SH_IR;
            EX1_IR:  state_d = Tms ? UPD_IR : PAU_IR;
            PAU_IR:  state_d = Tms ? EX2_IR : PAU_IR;
            EX2_IR:  state_d = Tms ? UPD_IR : SH_IR;
            UPD_IR:  state_d = Tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Active instruction: reload whenever TLR is entered, otherwise take the IR on Update-IR
    always_comb begin
        if (state_d == TLR)         ir_d = IR_RESET;
        else if (state_q == UPD_IR) ir_d = ir_sr_q;
        else                        ir_d = ir_q;
    end

    // Capture / shift / update of the IR and data registers
    always_comb begin
        ir_sr_d    = ir_sr_q;
        byp_d      = byp_q;
        user_sr_d  = user_sr_q;
        user_out_d = user_out_q;
        user_upd_d = 1'b0;
        case (state_q)
            CAP_IR: ir_sr_d = IR_WIDTH'(2'b01);
            SH_IR:  ir_sr_d = ir_shift_s[IR_WIDTH:1];
            CAP_DR: begin
                if (sel_user_s)     user_sr_d = UserDrIn;
                else if (!sel_id_s) byp_d     = 1'b0;
                else                byp_d     = byp_q;
            end
            SH_DR: begin
                if (sel_user_s)     user_sr_d = user_shift_s[DR_WIDTH:1];
                else if (!sel_id_s) byp_d     = Tdi;
                else                byp_d     = byp_q;
            end
            UPD_DR: begin
                if (sel_user_s) begin
                    user_out_d = user_sr_q;
                    user_upd_d = 1'b1;
                end else begin
                    user_out_d = user_out_q;
                    user_upd_d = 1'b0;
                end
            end
            default: user_upd_d = 1'b0;
        endcase
    end

    // Serial output mux, driven only while shifting
    always_comb begin
        tdo_s = 1'b0;
        case (state_q)
            SH_IR: tdo_s = ir_sr_q[0];
            SH_DR: begin
                if (sel_user_s)    tdo_s = user_sr_q[0];
                else if (sel_id_s) tdo_s = id_lsb_s;
                else               tdo_s = byp_q;
            end
            default: tdo_s = 1'b0;
        endcase
    end

    // State and register storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= TLR;
            ir_sr_q    <= {IR_WIDTH{1'b0}};
            ir_q       <= IR_RESET;
            byp_q      <= 1'b0;
            user_sr_q  <= {DR_WIDTH{1'b0}};
            user_out_q <= {DR_WIDTH{1'b0}};
            user_upd_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_sr_q    <= ir_sr_d;
            ir_q       <= ir_d;
            byp_q      <= byp_d;
            user_sr_q  <= user_sr_d;
            user_out_q <= user_out_d;
            user_upd_q <= user_upd_d;
        end
    end

    assign Tdo        = tdo_s;
    assign TdoEn      = (state_q == SH_DR) || (state_q == SH_IR);
    assign TapState   = state_q;
    assign IrValue    = ir_q;
    assign UserDrOut  = user_out_q;
    assign UserUpdate = user_upd_q;
endmodule
